// File: rtl/mem_port_arbiter.sv
// Two-master Avalon-MM port arbiter. Round-robin grant at transaction
// boundaries, write bursts lock the port, and read beats are steered back
// to their issuer through an in-order tag FIFO.
module mem_port_arbiter #(
  parameter int ADDR_W    = 31,
  parameter int DATA_W    = 128,
  parameter int BURST_W   = 11,
  parameter int BE_W      = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m0_read_i,
  input  logic               m0_write_i,
  input  logic [ADDR_W-1:0]  m0_address_i,
  input  logic [DATA_W-1:0]  m0_writedata_i,
  input  logic [BURST_W-1:0] m0_burstcount_i,
  input  logic [BE_W-1:0]    m0_byteenable_i,
  output logic               m0_waitrequest_o,
  output logic               m0_readdatavalid_o,
  output logic [DATA_W-1:0]  m0_readdata_o,
  input  logic               m1_read_i,
  input  logic               m1_write_i,
  input  logic [ADDR_W-1:0]  m1_address_i,
  input  logic [DATA_W-1:0]  m1_writedata_i,
  input  logic [BURST_W-1:0] m1_burstcount_i,
  input  logic [BE_W-1:0]    m1_byteenable_i,
  output logic               m1_waitrequest_o,
  output logic               m1_readdatavalid_o,
  output logic [DATA_W-1:0]  m1_readdata_o,
  input  logic               mem_waitrequest_i,
  input  logic               mem_readdatavalid_i,
  input  logic [DATA_W-1:0]  mem_readdata_i,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_address_o,
  output logic [DATA_W-1:0]  mem_writedata_o,
  output logic [BURST_W-1:0] mem_burstcount_o,
  output logic [BE_W-1:0]    mem_byteenable_o,
  output logic               rd_err_o,
  output logic               busy_o
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [BURST_W-1:0] BC_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GRANT, WBURST} state_t;

  state_t             state, state_nxt;
  logic               grant, grant_nxt, rr_ptr, rr_ptr_nxt, winner;
  logic [BURST_W-1:0] beats_left, beats_left_nxt;

  // tag FIFO: one entry per accepted read command
  logic [TAG_DEPTH-1:0] tag_id;
  logic [BURST_W-1:0]   tag_bc [TAG_DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, push, pop;
  logic [BURST_W-1:0]   rcnt, head_bc, cur_rem, push_bc;
  logic                 head_loaded, head_id, rd_hit;

  logic               g_read, g_write, elig0, elig1;
  logic [BURST_W-1:0] g_bc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign busy_o = (state != IDLE) || !empty;

  assign elig0 = m0_write_i || (m0_read_i && !full);
  assign elig1 = m1_write_i || (m1_read_i && !full);

  // data path always follows the registered grant; strobes gate it
  assign g_read           = grant ? m1_read_i       : m0_read_i;
  assign g_write          = grant ? m1_write_i      : m0_write_i;
  assign g_bc             = grant ? m1_burstcount_i : m0_burstcount_i;
  assign mem_address_o    = grant ? m1_address_i    : m0_address_i;
  assign mem_writedata_o  = grant ? m1_writedata_i  : m0_writedata_i;
  assign mem_byteenable_o = grant ? m1_byteenable_i : m0_byteenable_i;
  assign mem_burstcount_o = g_bc;
  assign push_bc          = (g_bc == '0) ? BC_ONE : g_bc;

  assign m0_readdata_o = mem_readdata_i;
  assign m1_readdata_o = mem_readdata_i;

  // read return: zero-latency steering from the FIFO head
  assign head_id = tag_id[rd_ptr[PW-1:0]];
  assign head_bc = tag_bc[rd_ptr[PW-1:0]];
  assign cur_rem = head_loaded ? rcnt : head_bc;
  assign rd_hit  = mem_readdatavalid_i && !empty;
  assign pop     = rd_hit && (cur_rem == BC_ONE);
  assign m0_readdatavalid_o = rd_hit && !head_id;
  assign m1_readdatavalid_o = rd_hit &&  head_id;

  // arbitration FSM: next state, strobes and waitrequests
  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    rr_ptr_nxt       = rr_ptr;
    beats_left_nxt   = beats_left;
    winner           = 1'b0;
    push             = 1'b0;
    mem_read_o       = 1'b0;
    mem_write_o      = 1'b0;
    m0_waitrequest_o = 1'b1;
    m1_waitrequest_o = 1'b1;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          winner     = (elig0 && elig1) ? rr_ptr : elig1;
          grant_nxt  = winner;
          rr_ptr_nxt = ~winner;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        mem_write_o = g_write;
        mem_read_o  = g_read && !g_write;
        if (grant) m1_waitrequest_o = mem_waitrequest_i;
        else       m0_waitrequest_o = mem_waitrequest_i;
        if (!g_read && !g_write) begin
          state_nxt = IDLE;
        end else if (!mem_waitrequest_i) begin
          if (g_write) begin
            if (g_bc > BC_ONE) begin
              beats_left_nxt = g_bc - BC_ONE;
              state_nxt      = WBURST;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WBURST: begin
        mem_write_o = g_write;
        if (grant) m1_waitrequest_o = mem_waitrequest_i;
        else       m0_waitrequest_o = mem_waitrequest_i;
        if (g_write && !mem_waitrequest_i) begin
          beats_left_nxt = beats_left - BC_ONE;
          if (beats_left == BC_ONE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, grant and round-robin registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      rr_ptr     <= 1'b0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  // FIFO pointers, head beat counter and sticky spurious-response flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_id      <= '0;
      rcnt        <= '0;
      head_loaded <= 1'b0;
      rd_err_o    <= 1'b0;
    end else begin
      if (push) begin
        tag_id[wr_ptr[PW-1:0]] <= grant;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_hit) begin
        if (pop) begin
          rd_ptr      <= rd_ptr + 1'b1;
          head_loaded <= 1'b0;
        end else begin
          rcnt        <= cur_rem - BC_ONE;
          head_loaded <= 1'b1;
        end
      end
      if (mem_readdatavalid_i && empty) rd_err_o <= 1'b1;
    end
  end

  // burst length storage needs no reset; validity comes from the pointers
  always_ff @(posedge clk_i) begin
    if (push) tag_bc[wr_ptr[PW-1:0]] <= push_bc;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external Avalon-MM memory port between two burst-capable masters: m0 is the checker transmitter, m1 is an auxiliary requester such as a preload/debug engine.
- Round-robin arbitration happens at transaction boundaries. A write burst holds the port until its last beat is accepted.
- Read responses are routed back to the issuing master through an in-order tag FIFO.
- Sits between the master-side logic and the memory controller, in the clk_mem_i domain.

Parameters:
ADDR_W, 31, address width
DATA_W, 128, data width
BURST_W, 11, burstcount width
BE_W, 16, byteenable width (DATA_W/8)
TAG_DEPTH, 8, outstanding read bursts tracked (power of 2, >=2)

Ports:
clk_i  in  1  memory clock
rst_i  in  1  asynchronous reset, active low (asserted when 0)
mN_read_i / mN_write_i  in  1  request strobes, N=0,1
mN_address_i  in  ADDR_W  master address
mN_writedata_i  in  DATA_W  master write data
mN_burstcount_i  in  BURST_W  master burst length
mN_byteenable_i  in  BE_W  master byte enables
mN_waitrequest_o  out  1  stall to master N
mN_readdatavalid_o  out  1  read beat belongs to master N
mN_readdata_o  out  DATA_W  broadcast copy of mem_readdata_i
mem_waitrequest_i  in  1  slave stall
mem_readdatavalid_i  in  1  slave read beat valid
mem_readdata_i  in  DATA_W  slave read data
mem_read_o / mem_write_o  out  1  muxed strobes
mem_address_o  out  ADDR_W  muxed address
mem_writedata_o  out  DATA_W  muxed write data
mem_burstcount_o  out  BURST_W  muxed burst length
mem_byteenable_o  out  BE_W  muxed byte enables
rd_err_o  out  1  sticky: readdatavalid arrived with no tag pending
busy_o  out  1  state != IDLE or tag FIFO not empty

Behaviour:
- Reset (rst_i=0, asynchronous) forces the following, and aborts any in-flight burst with no completion:
  - state IDLE, tag FIFO empty, rr_ptr=0, rd_err_o=0
  - mem_read_o=0, mem_write_o=0
  - mN_waitrequest_o=1, mN_readdatavalid_o=0
- Eligibility:
  - Master N is eligible if mN_write_i=1, or if mN_read_i=1 and the tag FIFO is not full.
  - read=write=1 on the same master is treated as a write.
- State IDLE:
  - All mN_waitrequest_o=1, mem strobes 0.
  - If any master is eligible, register grant=winner and go to GRANT.
  - Winner is the only eligible master, or, if both are eligible, master rr_ptr.
  - On grant, rr_ptr <= ~winner, so the winner gets lowest priority next time.
  - Grant latency is 1 cycle from first request sampling.
- State GRANT (reads and the first write beat):
  - mem_* outputs mirror the granted master's inputs combinationally.
  - m{grant}_waitrequest_o = mem_waitrequest_i; the other master's waitrequest_o stays 1.
  - Read accepted (mem_read_o & !mem_waitrequest_i): push {grant, burstcount} to the tag FIFO; next state IDLE.
  - Write accepted with burstcount<=1: next state IDLE.
  - Write accepted with burstcount>1: beats_left <= burstcount-1; next state WBURST.
- State WBURST:
  - Grant is locked and muxing is as in GRANT.
  - Decrement beats_left on each accepted beat (mem_write_o & !mem_waitrequest_i).
  - On the accepted beat with beats_left==1, return to IDLE.
  - Master gaps (write deasserted) keep the lock.
  - burstcount is sampled only at the first beat.
- burstcount=0 is treated as 1 everywhere: tag FIFO entry and write count.
- Read return path, zero-latency combinational:
  - When mem_readdatavalid_i=1 and the FIFO is not empty, assert m{head.id}_readdatavalid_o and decrement head beat counter rcnt.
  - rcnt loads from head.burstcount when a new head becomes active.
  - On the last beat, pop the head.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - mem_readdatavalid_i with the FIFO empty sets rd_err_o, which stays set until reset; no master readdatavalid is asserted.
- Tag FIFO full:
  - Reads are ineligible; pending writes still win.
  - A read already in GRANT is never blocked, because eligibility was checked before grant.
- A master dropping its request while in GRANT before acceptance returns the arbiter to IDLE the next cycle with no push.
- A granted master must hold its address, data and controls stable while waitrequest is high.
- Arbitration never preempts a write burst. Reads are single-command and never hold the port beyond acceptance.

Test Plan:
1. Reset checks, and both masters reading at the same time:
   - Hold rst_i=0 → mem_read_o=0, mem_write_o=0, m0_waitrequest_o=m1_waitrequest_o=1, busy_o=0.
   - Release reset; m0 and m1 both read with burstcount=1 → m0 is granted first (rr_ptr=0), then m1; two tags are pushed.
2. Write burst lock:
   - m0 writes burstcount=4 with mem_waitrequest_i high 2 cycles mid-burst; m1 reads throughout.
   - → m1_waitrequest_o stays 1 until m0's 4th beat is accepted; m1 is granted on the next arbitration.
3. Read routing:
   - m0 reads burst 3, then m1 reads burst 2; slave returns 5 beats back-to-back.
   - → m0_readdatavalid_o on beats 1-3, m1_readdatavalid_o on beats 4-5; FIFO empty after.
4. Tag FIFO full (TAG_DEPTH=8):
   - 8 unreturned reads are outstanding; m1 issues a 9th read and m0 issues a write.
   - → the read stalls and the write is granted.
   - After one response burst completes (pop), the read is granted.
5. Spurious response:
   - mem_readdatavalid_i=1 with the FIFO empty → rd_err_o=1 and stays set; neither mN_readdatavalid_o asserts.
6. Reset mid-burst:
   - Assert rst_i=0 during beat 2 of a burstcount=8 write → all outputs return to reset values immediately; after release, a new m1 read is granted in 1 cycle.
